actor_port_fifo: RTL
====================

# actor_port_fifo

Token FIFO joining an actor output port (DATA/COUNT/SEND/RDY) to the input port (DATA/COUNT/SEND/ACK) of the next actor in a dataflow image-processing network. It is the receiving end for the producer's output port and the transmitting end for the consumer's input port. One instance sits on every actor-to-actor connection of the benchmark top levels.

## Interface
Parameters:
- WIDTH, 8, token data width.
- DEPTH, 16, token capacity; power of two, at least 2.
- AW, log2(DEPTH), pointer width; derived, not overridden.

Ports:
- CLK  in  1  clock; all state changes on its rising edge.
- RESET  in  1  reset, asynchronous, active-high.
- In_DATA  in  WIDTH  token from the producer.
- In_COUNT  in  16  producer token count; must be 1; otherwise ignored.
- In_SEND  in  1  producer write strobe, one token per cycle high.
- In_RDY  out  1  space available; producer may assert In_SEND this cycle.
- In_ACK  out  1  write accepted this cycle.
- Out_DATA  out  WIDTH  head token.
- Out_COUNT  out  16  occupancy, zero-extended.
- Out_SEND  out  1  head token valid (FIFO non-empty).
- Out_ACK  in  1  consumer pops the head token this cycle.

## Operation
- State: mem[DEPTH], wr_ptr and rd_ptr (AW bits, wrap modulo DEPTH), count (AW+1 bits, 0..DEPTH).
- full = (count == DEPTH). empty = (count == 0).
- In_RDY = ~full & ~RESET.
- push = In_SEND & ~full. In_ACK = push (combinational).
- On push: mem[wr_ptr] <= In_DATA, wr_ptr += 1.
- Out_SEND = ~empty.
- Out_DATA = mem[rd_ptr] when non-empty, else 0.
- pop = Out_ACK & ~empty. On pop: rd_ptr += 1.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Push while full is dropped, with no ACK and no state change.
- Pop while empty is ignored.
- Full with simultaneous In_SEND and Out_ACK: only the pop happens, because In_RDY was low.
- Empty with simultaneous In_SEND and Out_ACK: only the push happens. There is no bypass, so the consumer sees the token next cycle.

## Timing
- Reset values: wr_ptr = rd_ptr = count = 0. Outputs: In_RDY=0 while RESET is high, then 1. In_ACK=0, Out_SEND=0, Out_DATA=0, Out_COUNT=0.
- RESET asserted mid-operation clears all queued tokens immediately (asynchronous). Memory contents are not cleared.
- Write-to-read latency is 1 cycle: a token pushed at edge N gives Out_SEND=1 with that data after edge N.
- Throughput is 1 token/cycle on each side, concurrently.
- Out_COUNT and In_RDY reflect registered state only. They have no combinational path from In_SEND or Out_ACK.
- In_ACK has a combinational path from In_SEND. Out_DATA is combinational from rd_ptr and memory.

## Configuration
- ACTOR_PORT_FIFO_ERR_EN defined: adds output ERR (1 bit, sticky, reset 0). It is set on the edge after any of these events:
  - In_SEND while full;
  - Out_ACK while empty;
  - In_SEND with In_COUNT != 1.
  
  ERR is cleared only by RESET.
- Undefined: no ERR port, and the same events are silently ignored as described above.

## Structure
- Shared package actor_port_pkg holds:
  - COUNT_W = 16, the port COUNT width;
  - the default token width, 8;
  - the log2 helper function used to derive AW.
- Sub-module actor_port_fifo_mem: DEPTH x WIDTH memory with one synchronous write port and one asynchronous read port (distributed RAM). All pointer, count and handshake logic stays in the parent.

## Test plan
- Reset release, then 3 pushes of 0x11, 0x22, 0x33 with no pops → In_ACK high each push cycle. After the third edge: Out_COUNT=3, Out_SEND=1, Out_DATA=0x11.
- Fill DEPTH=16 tokens 0..15, then hold In_SEND=1 → In_RDY=0 and In_ACK=0. Out_COUNT stays 16. Draining yields 0..15 in order; the pointers wrap correctly on a second fill.
- Continuous push and pop every cycle from count=4 → count stays 4 and 1 token/cycle passes. Output order equals input order across at least 3 pointer wraps.
- Empty FIFO with In_SEND=1 (0xA5) and Out_ACK=1 in the same cycle → push accepted, pop ignored. Next cycle: Out_SEND=1, Out_DATA=0xA5, Out_COUNT=1.
- RESET pulsed asynchronously (mid-cycle) with count=7 → Out_SEND, Out_COUNT and In_RDY drop immediately. After release: count=0, In_RDY=1, and the old tokens are never presented.
- With ACTOR_PORT_FIFO_ERR_EN: Out_ACK on empty → ERR=1 after the edge and stays 1 through later normal traffic until RESET.

Source files
------------

// File: rtl/actor_port_pkg.sv
// Shared definitions for actor port connections: COUNT width, default token width,
// and the log2 helper used to size FIFO pointers.
package actor_port_pkg;

    localparam int unsigned COUNT_W       = 16;
    localparam int unsigned DEFAULT_WIDTH = 8;

    function automatic int unsigned log2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/actor_port_fifo_if.sv
// Actor port bundle (DATA/COUNT/SEND with RDY/ACK). master/slave cover the write side;
// source/sink cover the read side, where RDY plays no part.
interface actor_port_fifo_if
    import actor_port_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0]   DATA;
    logic [COUNT_W-1:0] COUNT;
    logic               SEND;
    logic               RDY;
    logic               ACK;

    modport master (output DATA, COUNT, SEND, input  RDY, ACK);
    modport slave  (input  DATA, COUNT, SEND, output RDY, ACK);
    modport source (output DATA, COUNT, SEND, input  ACK);
    modport sink   (input  DATA, COUNT, SEND, output ACK);
endinterface

// File: rtl/actor_port_fifo_mem.sv
// DEPTH x WIDTH token storage: one synchronous write port, one asynchronous read port.
module actor_port_fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             CLK,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/actor_port_fifo.sv
// Token FIFO between a producer actor output port and a consumer actor input port.
// Define ACTOR_PORT_FIFO_ERR_EN to add the sticky ERR protocol-violation output.
module actor_port_fifo
    import actor_port_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = 16
) (
    input  logic CLK,
    input  logic RESET,
    actor_port_fifo_if.slave  in_port,
    actor_port_fifo_if.source out_port
`ifdef ACTOR_PORT_FIFO_ERR_EN
    ,
    output logic ERR
`endif
);
    localparam int unsigned AW       = log2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_full, w_empty, w_push, w_pop;
    logic [WIDTH-1:0] w_rdata;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = in_port.SEND & ~w_full;
    assign w_pop   = out_port.ACK & ~w_empty;

    assign in_port.RDY    = ~w_full & ~RESET;
    assign in_port.ACK    = w_push;
    assign out_port.SEND  = ~w_empty;
    assign out_port.COUNT = COUNT_W'(r_count);
    // Memory is never cleared, so stale contents must be masked while empty.
    assign out_port.DATA  = w_empty ? '0 : w_rdata;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    actor_port_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .CLK     (CLK),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (in_port.DATA),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

`ifdef ACTOR_PORT_FIFO_ERR_EN
    logic r_err;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_err <= 1'b0;
        end else if ((in_port.SEND & w_full) | (out_port.ACK & w_empty) |
                     (in_port.SEND & (in_port.COUNT != COUNT_W'(1)))) begin
            r_err <= 1'b1;
        end
    end

    assign ERR = r_err;
`else
    logic w_unused_count;
    assign w_unused_count = ^in_port.COUNT;
`endif
endmodule
